// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the direct-mapped data cache.
//   - default widths for the word address, data word and line index
//   - FSM state encoding for cache_dm
//   - tag_of / index_of helpers that split a word address into tag and index
// Optional feature macro used by cache_dm: CACHE_STATS_EN.
package cache_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 4;
    localparam int STAT_W      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_e;

    // The index is the low address bits; callers cast the result to INDEX_W.
    function automatic logic [31:0] index_of(input logic [31:0] addr, input int unsigned index_w);
        return addr & ((32'd1 << index_w) - 32'd1);
    endfunction

    // The tag is everything above the index; callers cast the result to the tag width.
    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned index_w);
        return addr >> index_w;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage for a direct-mapped cache, one word per line.
// Ports:
//   clk, reset         clock, asynchronous active-high reset (clears valid bits only)
//   rd_idx             combinational read index
//   rd_valid/tag/data  contents of line rd_idx
//   wr_en              write strobe (synchronous)
//   wr_fill            1: fill (data + tag + valid), 0: data-only update of a resident line
//   wr_idx/tag/data    write index, tag and data
module cache_line_array
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INDEX_W-1:0]        rd_idx,
    output logic                      rd_valid,
    output logic [ADDR_W-INDEX_W-1:0] rd_tag,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      wr_en,
    input  logic                      wr_fill,
    input  logic [INDEX_W-1:0]        wr_idx,
    input  logic [ADDR_W-INDEX_W-1:0] wr_tag,
    input  logic [DATA_W-1:0]         wr_data
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
            if (wr_fill) tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_dm.sv
// cache_dm: direct-mapped, write-through, no-write-allocate data cache sitting
// between the multicycle core's Memory stage and the backing data memory.
// Every access raises stall for at least one cycle; a request held after
// completion is not re-serviced until both r_en and w_en drop.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   r_en, w_en                 core read / write request (write wins)
//   address, data              word address and store data
//   stall                      busy, registered
//   saida_cache                load result, held until the next read completes
//   mem_addr, mem_wdata        backing-memory address / write data
//   mem_rd, mem_wr             backing-memory strobes, held until mem_ready
//   mem_rdata, mem_ready       backing-memory read data and one-cycle completion
// Optional feature: define CACHE_STATS_EN to add hit_count / miss_count
// (16-bit, saturating, incremented once per LOOKUP by outcome).
module cache_dm
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r_en,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              stall,
    output logic [DATA_W-1:0] saida_cache,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_wr_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               hit;
    logic               arr_we;
    logic               arr_fill;
    logic [DATA_W-1:0]  arr_wdata;

    assign idx = INDEX_W'(index_of(32'(addr_q), INDEX_W));
    assign tag = TAG_W'(tag_of(32'(addr_q), INDEX_W));
    assign hit = line_valid && (line_tag == tag);

    // Write hits update data in place; completed read misses fill the whole line.
    assign arr_fill  = (state_q == MEM_RD);
    assign arr_we    = (state_q == LOOKUP && is_wr_q && hit) || (state_q == MEM_RD && mem_ready);
    assign arr_wdata = arr_fill ? mem_rdata : wdata_q;

    cache_line_array #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_fill  (arr_fill),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            stall       <= 1'b0;
            saida_cache <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r_en || w_en) begin
                        addr_q  <= address;
                        wdata_q <= data;
                        is_wr_q <= w_en;
                        stall   <= 1'b1;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (is_wr_q) begin
                        // Write-through: memory is written on hit and miss alike.
                        mem_wr    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= wdata_q;
                        state_q   <= MEM_WR;
                    end else if (hit) begin
                        saida_cache <= line_data;
                        stall       <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= addr_q;
                        state_q  <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ready) begin
                        saida_cache <= mem_rdata;
                        mem_rd      <= 1'b0;
                        stall       <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        mem_wr  <= 1'b0;
                        stall   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!r_en && !w_en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
